// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The controller side drives start and operands; the adder returns status and result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Result registers update only on the edge that enters DONE.
module full_add (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // The LSB of the partial sum is never read back before it shifts out,
    // so only the upper WIDTH-1 bits are stored; s_full is the complete sum.
    logic [WIDTH-2:0] s_sr;
    logic [WIDTH-1:0] s_full;
    logic             c_reg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             s_bit;
    logic             c_next;
    logic             last;

    full_add u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (c_reg),
        .s  (s_bit),
        .co (c_next)
    );

    assign s_full = {s_bit, s_sr};
    assign last   = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            c_reg  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        c_reg <= bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    s_sr  <= s_full[WIDTH-1:1];
                    c_reg <= c_next;
                    cnt   <= cnt + 1'b1;
                    // Publish on the final bit so the result is valid during the done cycle.
                    if (last) begin
                        sum_q  <= s_full;
                        cout_q <= c_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8) against an a+b+cin model.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    endfunction

    // Launch one addition; optionally pulse a stray start with new operands at run cycle inj_k.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int inj_k, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output logic [W-1:0] s, output logic co,
                          output int lat, output int nbusy, output int viol);
        logic [W-1:0] ps;
        logic         pc;
        ps = bus.sum;
        pc = bus.cout;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1; nbusy = 0; viol = 0;
        while (!bus.done && lat < 30) begin
            if (bus.busy) nbusy++;
            if (bus.sum !== ps || bus.cout !== pc) viol++;
            if (lat == inj_k) begin
                bus.a = ia; bus.b = ib; bus.cin = ~c; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        if (bus.busy) viol++;
        s  = bus.sum;
        co = bus.cout;
    endtask

    task automatic add_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input int inj_k, input logic [W-1:0] ia,
                                 input logic [W-1:0] ib);
        logic [W-1:0] s;
        logic         co;
        logic [W:0]   exp;
        int           lat, nbusy, viol;
        exp = model(a, b, c);
        do_add(a, b, c, inj_k, ia, ib, s, co, lat, nbusy, viol);
        check({tag, "_lat"}, lat, W + 1);
        check({tag, "_busy"}, nbusy, W);
        check({tag, "_hold"}, viol, 0);
        check({tag, "_res"}, {co, s}, exp);
        @(negedge clk);
        check({tag, "_pulse"}, {bus.done, bus.busy}, 2'b00);
    endtask

    initial begin
        int nd, last, idx, k;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

        // Reset with random inputs
        repeat (2) begin
            @(negedge clk);
            bus.a = W'($urandom); bus.b = W'($urandom); bus.start = 1'($urandom);
        end
        @(negedge clk);
        check("rst_out", {bus.busy, bus.done, bus.cout, bus.sum}, '0);
        rst = 1'b0; bus.start = 1'b0;
        nd = 0;
        repeat (10) begin @(negedge clk); if (bus.done) nd++; end
        check("rst_nodone", nd, 0);

        add_and_check("basic", 8'h35, 8'h4A, 1'b0, -1, '0, '0);
        check("basic_sum", bus.sum, 8'h7F);
        add_and_check("ripple1", 8'hFF, 8'h01, 1'b0, -1, '0, '0);
        check("ripple1_res", {bus.cout, bus.sum}, 9'h100);
        add_and_check("ripple2", 8'hFF, 8'hFF, 1'b1, -1, '0, '0);
        check("ripple2_res", {bus.cout, bus.sum}, 9'h1FF);

        add_and_check("ign", 8'h10, 8'h20, 1'b1, 3, 8'hAA, 8'h55);
        check("ign_res", {bus.cout, bus.sum}, 9'h031);
        nd = 0;
        repeat (12) begin @(negedge clk); if (bus.done) nd++; end
        check("ign_nodone", nd, 0);

        // Reset in the middle of a run
        @(negedge clk);
        bus.a = 8'hC3; bus.b = 8'h3C; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst", {bus.busy, bus.done, bus.cout, bus.sum}, '0);
        nd = 0;
        repeat (12) begin @(negedge clk); if (bus.done) nd++; end
        check("mid_nodone", nd, 0);
        add_and_check("post_rst", 8'h01, 8'h02, 1'b0, -1, '0, '0);

        // Back-to-back with start held high
        @(negedge clk);
        bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b0; bus.start = 1'b1;
        nd = 0; last = -1;
        for (idx = 0; idx < 62; idx++) begin
            @(negedge clk);
            if (bus.busy && bus.done) check("b2b_overlap", 1, 0);
            if (bus.done) begin
                if (last >= 0) check("b2b_gap", idx - last, W + 2);
                check("b2b_res", {bus.cout, bus.sum}, 9'h100);
                last = idx;
                nd++;
            end
        end
        check("b2b_count", nd >= 5, 1);
        bus.start = 1'b0;
        k = 0;
        while ((bus.busy || bus.done) && k < 20) begin @(negedge clk); k++; end
        check("b2b_idle", k < 20, 1);

        // Random operands, with stray starts and operand changes during the run
        for (int n = 0; n < 200; n++) begin
            logic [W-1:0] ra, rb, s;
            logic         rc, co;
            int           inj, lat, nbusy, viol;
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W)) : -1;
            do_add(ra, rb, rc, inj, W'($urandom), W'($urandom), s, co, lat, nbusy, viol);
            check("rnd_res", {co, s}, model(ra, rb, rc));
            if (lat != W + 1 || nbusy != W || viol != 0) check("rnd_timing", {lat, nbusy, viol}, {W + 1, W, 0});
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
